// File: rtl/gdiv_multi.sv
// gdiv_multi: multi-channel unipolar stochastic divider.
// Each channel runs a saturating up/down counter in a feedback loop so that
// quotient tracks dividend/divisor. The optional sticky saturation flags
// (satHi/satLo) are built only when GDIV_SAT_FLAG_EN is defined.
module gdiv_multi #(
  parameter int unsigned CWIDTH = 5,
  parameter int unsigned NCH    = 4,
  parameter int unsigned INIT   = 1 << (CWIDTH - 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clr,
  input  logic [NCH*CWIDTH-1:0]   randNum,
  input  logic [NCH-1:0]          dividend,
  input  logic [NCH-1:0]          divisor,
  output logic [NCH-1:0]          quotient
`ifdef GDIV_SAT_FLAG_EN
  ,
  output logic [NCH-1:0]          satHi,
  output logic [NCH-1:0]          satLo
`endif
);

  localparam logic [CWIDTH-1:0] L_INIT  = CWIDTH'(INIT);
  localparam logic [CWIDTH-1:0] L_FULL  = '1;
  localparam logic [CWIDTH-1:0] L_EMPTY = '0;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    logic [CWIDTH-1:0] r_cnt;
    logic [CWIDTH-1:0] w_rand;
    logic              w_inc;
    logic              w_dec;
    logic              w_up;
    logic              w_dn;

    assign w_rand      = randNum[g*CWIDTH +: CWIDTH];
    assign quotient[g] = (r_cnt >= w_rand);
    assign w_inc       = dividend[g];
    assign w_dec       = quotient[g] & divisor[g];
    assign w_up        = w_inc & ~w_dec & (r_cnt != L_FULL);
    assign w_dn        = ~w_inc & w_dec & (r_cnt != L_EMPTY);

    // Saturating counter: clear beats stall, inc/dec step by exactly one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= L_INIT;
      end else if (clr) begin
        r_cnt <= L_INIT;
      end else if (enable) begin
        if (w_up) begin
          r_cnt <= r_cnt + CWIDTH'(1);
        end else if (w_dn) begin
          r_cnt <= r_cnt - CWIDTH'(1);
        end
      end
    end

`ifdef GDIV_SAT_FLAG_EN
    logic r_sat_hi;
    logic r_sat_lo;
    logic w_hit_hi;
    logic w_hit_lo;

    assign w_hit_hi = w_inc & ~w_dec & (r_cnt == L_FULL);
    assign w_hit_lo = ~w_inc & w_dec & (r_cnt == L_EMPTY);

    // Sticky flags: set when a step is blocked by saturation, cleared by clr.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sat_hi <= 1'b0;
        r_sat_lo <= 1'b0;
      end else if (clr) begin
        r_sat_hi <= 1'b0;
        r_sat_lo <= 1'b0;
      end else if (enable) begin
        if (w_hit_hi) r_sat_hi <= 1'b1;
        if (w_hit_lo) r_sat_lo <= 1'b1;
      end
    end

    assign satHi[g] = r_sat_hi;
    assign satLo[g] = r_sat_lo;
`endif
  end

endmodule

// File: tb/tb_gdiv_multi.sv
// Self-checking bench for gdiv_multi: behavioural counter model checked on
// every cycle, plus directed probes with hand-computed quotient patterns.
module tb_gdiv_multi;

  localparam int unsigned CW   = 5;
  localparam int unsigned NCH  = 4;
  localparam int unsigned INIT = 16;
  localparam int          MAXC = (1 << CW) - 1;
  localparam int          NACC = 4096;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                clr;
  logic [NCH*CW-1:0]   randNum;
  logic [NCH-1:0]      dividend;
  logic [NCH-1:0]      divisor;
  logic [NCH-1:0]      quotient;
`ifdef GDIV_SAT_FLAG_EN
  logic [NCH-1:0]      satHi;
  logic [NCH-1:0]      satLo;
`endif

  always #5 clk = ~clk;

  gdiv_multi #(.CWIDTH(CW), .NCH(NCH), .INIT(INIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clr      (clr),
    .randNum  (randNum),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient)
`ifdef GDIV_SAT_FLAG_EN
    ,
    .satHi    (satHi),
    .satLo    (satLo)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  int m_cnt [NCH];
  bit m_hi  [NCH];
  bit m_lo  [NCH];
  int ones  [NCH];

  function automatic int lane(int i);
    return int'(randNum[i*CW +: CW]);
  endfunction

  task automatic cmp(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: counter value per channel as a plain integer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] <= INIT;
        m_hi[i]  <= 1'b0;
        m_lo[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr) begin
          m_cnt[i] <= INIT;
          m_hi[i]  <= 1'b0;
          m_lo[i]  <= 1'b0;
        end else if (enable) begin
          if (dividend[i] && !(divisor[i] && m_cnt[i] >= lane(i))) begin
            if (m_cnt[i] < MAXC) m_cnt[i] <= m_cnt[i] + 1;
            else                 m_hi[i]  <= 1'b1;
          end else if (!dividend[i] && divisor[i] && m_cnt[i] >= lane(i)) begin
            if (m_cnt[i] > 0) m_cnt[i] <= m_cnt[i] - 1;
            else              m_lo[i]  <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) begin
        cmp($sformatf("q_ch%0d", i), int'(quotient[i]), (m_cnt[i] >= lane(i)) ? 1 : 0);
`ifdef GDIV_SAT_FLAG_EN
        cmp($sformatf("sathi_ch%0d", i), int'(satHi[i]), int'(m_hi[i]));
        cmp($sformatf("satlo_ch%0d", i), int'(satLo[i]), int'(m_lo[i]));
`endif
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int i, int v);
    randNum[i*CW +: CW] = CW'(v);
  endtask

  task automatic set_rand_all(int v);
    for (int i = 0; i < NCH; i++) set_lane(i, v);
  endtask

  task automatic probe(string name, logic [NCH-1:0] exp);
    @(negedge clk);
    cmp(name, int'(quotient), int'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string name, int exp);
    for (int i = 0; i < NCH; i++) cmp($sformatf("%s_ch%0d", name, i), m_cnt[i], exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    clr      = 1'b0;
    dividend = '0;
    divisor  = '0;
    set_rand_all(16);
    cyc(2);
    chk_on = 1'b1;

    // Reset value INIT=16 seen through the comparator
    probe("rst_rand16", 4'b1111);
    set_rand_all(17);
    probe("rst_rand17", 4'b0000);
    check_model("rst_cnt", 16);
    rst_n = 1'b1;

    // Saturate up: 20 increments from 16 must stop at 31
    enable = 1'b1; dividend = '1; divisor = '0; set_rand_all(0);
    cyc(20);
    enable = 1'b0; dividend = '0; set_rand_all(31);
    probe("satup_rand31", 4'b1111);
    check_model("satup_cnt", 31);
`ifdef GDIV_SAT_FLAG_EN
    cmp("satup_flag_hi", int'(satHi), 15);
`endif

    // Saturate down: 40 decrements from 31 must stop at 0
    enable = 1'b1; divisor = '1; set_rand_all(0);
    cyc(40);
    enable = 1'b0;
    probe("satdn_rand0", 4'b1111);
    set_rand_all(1);
    probe("satdn_rand1", 4'b0000);
    check_model("satdn_cnt", 0);
`ifdef GDIV_SAT_FLAG_EN
    cmp("satdn_flag_lo", int'(satLo), 15);
    cmp("satdn_flag_hi_sticky", int'(satHi), 15);
`endif

    // Clear back to 16, then drive to 20 and stall
    divisor = '0;
    clr = 1'b1; cyc(1); clr = 1'b0;
    set_rand_all(16);
    probe("clr1_rand16", 4'b1111);
`ifdef GDIV_SAT_FLAG_EN
    cmp("clr1_flags", int'({satHi, satLo}), 0);
`endif
    enable = 1'b1; dividend = '1; set_rand_all(0);
    cyc(4);
    enable = 1'b0;
    cyc(5);
    set_rand_all(20);
    probe("stall_rand20", 4'b1111);
    set_rand_all(21);
    probe("stall_rand21", 4'b0000);
    check_model("stall_cnt", 20);
    clr = 1'b1; cyc(1); clr = 1'b0;
    set_rand_all(16);
    probe("clr2_rand16", 4'b1111);
    set_rand_all(17);
    probe("clr2_rand17", 4'b0000);

    // Simultaneous inc and dec hold the counter
    enable = 1'b1; dividend = '1; divisor = '1; set_rand_all(0);
    cyc(10);
    enable = 1'b0;
    set_rand_all(16);
    probe("incdec_rand16", 4'b1111);
    set_rand_all(17);
    probe("incdec_rand17", 4'b0000);

    // Independence: ch0 up, ch1 down, ch2/ch3 idle for 3 cycles
    enable = 1'b1; dividend = 4'b0001; divisor = 4'b0010; set_rand_all(0);
    cyc(3);
    enable = 1'b0;
    set_lane(0, 19); set_lane(1, 13); set_lane(2, 16); set_lane(3, 16);
    probe("indep_at", 4'b1111);
    set_lane(0, 20); set_lane(1, 14); set_lane(2, 17); set_lane(3, 17);
    probe("indep_above", 4'b0000);

    // Accuracy: dividend p=0.25, divisor p=0.5 -> quotient density 0.5
    clr = 1'b1; cyc(1); clr = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < NCH; i++) ones[i] = 0;
    for (int n = 0; n < NACC; n++) begin
      for (int i = 0; i < NCH; i++) begin
        set_lane(i, int'($urandom_range(MAXC)));
        dividend[i] = ($urandom_range(3) == 0);
        divisor[i]  = ($urandom_range(1) == 1);
      end
      @(negedge clk);
      for (int i = 0; i < NCH; i++) ones[i] += int'(quotient[i]);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (ones[i] < (NACC * 45) / 100 || ones[i] > (NACC * 55) / 100) begin
        bad++;
        $display("FAIL density_ch%0d: got %0d ones of %0d want %0d..%0d",
                 i, ones[i], NACC, (NACC * 45) / 100, (NACC * 55) / 100);
      end
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
